// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter.
// Holds FSM state, grantee encoding and the wait-counter width.
package mem_bus_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to time memory wait states.
// Ports: clk, rst (async clear), load/load_val, dec, zero flag.
module mem_wait_counter
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory between instruction fetch and data load/store,
// inserting region-dependent wait states and driving OE_bar/WE_bar.
// Ports: CLK/RST, FETCH_* and DATA_* REQ/ACK requesters,
// MEM_* memory bus and strobes, BUSY while not idle.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] RAM_BASE       = 16'h8000,
    parameter int          ROM_READ_WAIT  = 1,
    parameter int          RAM_READ_WAIT  = 0,
    parameter int          RAM_WRITE_WAIT = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FETCH_REQ,
    input  logic [15:0] FETCH_ADDR,
    output logic        FETCH_ACK,
    output logic [7:0]  FETCH_DATA,
    input  logic        DATA_REQ,
    input  logic        DATA_WE,
    input  logic [15:0] DATA_ADDR,
    input  logic [7:0]  DATA_WDATA,
    output logic        DATA_ACK,
    output logic [7:0]  DATA_RDATA,
    output logic        DATA_ERR,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic        MEM_OE_bar,
    output logic        MEM_WE_bar,
    output logic        BUSY
);

    localparam logic [CNT_W-1:0] ROM_RD_W = CNT_W'(ROM_READ_WAIT);
    localparam logic [CNT_W-1:0] RAM_RD_W = CNT_W'(RAM_READ_WAIT);
    localparam logic [CNT_W-1:0] RAM_WR_W = CNT_W'(RAM_WRITE_WAIT);

    state_t state, state_nx;
    gnt_t   gnt, last_gnt;
    logic   op_we, rom_wr;

    logic             grant, pick_data;
    logic [15:0]      req_addr;
    logic             req_we, req_ram;
    logic [CNT_W-1:0] wait_ld;
    logic             cnt_zero;

    // Grant decision; on a tie the side not served last wins.
    always_comb begin
        grant     = 1'b0;
        pick_data = 1'b0;
        if (state == ST_IDLE) begin
            if (FETCH_REQ && DATA_REQ) begin
                grant     = 1'b1;
                pick_data = (last_gnt == GNT_FETCH);
            end else if (FETCH_REQ) begin
                grant = 1'b1;
            end else if (DATA_REQ) begin
                grant     = 1'b1;
                pick_data = 1'b1;
            end
        end
        req_addr = pick_data ? DATA_ADDR : FETCH_ADDR;
        req_we   = pick_data & DATA_WE;
        req_ram  = (req_addr >= RAM_BASE);
        if (req_we) begin
            wait_ld = RAM_WR_W;
        end else if (req_ram) begin
            wait_ld = RAM_RD_W;
        end else begin
            wait_ld = ROM_RD_W;
        end
    end

    mem_wait_counter u_wait (
        .clk      (CLK),
        .rst      (RST),
        .load     (grant),
        .load_val (wait_ld),
        .dec      (state == ST_ACCESS),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (grant) state_nx = ST_ACCESS;
            ST_ACCESS: if (cnt_zero) state_nx = op_we ? ST_HOLD : ST_DONE;
            ST_HOLD:   state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            gnt        <= GNT_FETCH;
            last_gnt   <= GNT_DATA;
            op_we      <= 1'b0;
            rom_wr     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            FETCH_DATA <= '0;
            DATA_RDATA <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                gnt      <= pick_data ? GNT_DATA : GNT_FETCH;
                last_gnt <= pick_data ? GNT_DATA : GNT_FETCH;
                op_we    <= req_we;
                // ROM writes run the normal timing but never strobe WE
                rom_wr   <= req_we & ~req_ram;
                MEM_ADDR <= req_addr;
                if (pick_data) MEM_WDATA <= DATA_WDATA;
            end
            if (state == ST_ACCESS && cnt_zero && !op_we) begin
                if (gnt == GNT_DATA) begin
                    DATA_RDATA <= MEM_RDATA;
                end else begin
                    FETCH_DATA <= MEM_RDATA;
                end
            end
        end
    end

    // Strobes decode straight from state so reset releases them at once
    assign MEM_OE_bar = !(state == ST_ACCESS && !op_we);
    assign MEM_WE_bar = !(state == ST_ACCESS && op_we && !rom_wr);
    assign FETCH_ACK  = (state == ST_DONE) && (gnt == GNT_FETCH);
    assign DATA_ACK   = (state == ST_DONE) && (gnt == GNT_DATA);
    assign DATA_ERR   = DATA_ACK && rom_wr;
    assign BUSY       = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a latency-level
// reference model, a memory model and directed scenarios.
module tb_mem_bus_arbiter;

    localparam int ROM_RW = 1;
    localparam int RAM_RW = 0;
    localparam int RAM_WW = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ack;
    logic [7:0]  f_data;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [7:0]  d_wdata = '0;
    logic        d_ack;
    logic [7:0]  d_rdata;
    logic        d_err;
    logic [15:0] m_addr_o;
    logic [7:0]  m_wdata_o;
    logic [7:0]  m_rdata;
    logic        oe_bar, we_bar, busy;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16'h0010) return 8'hA5;
        return 8'(i ^ (i >> 8));
    endfunction

    mem_bus_arbiter #(
        .RAM_BASE       (16'h8000),
        .ROM_READ_WAIT  (ROM_RW),
        .RAM_READ_WAIT  (RAM_RW),
        .RAM_WRITE_WAIT (RAM_WW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .FETCH_REQ  (f_req),
        .FETCH_ADDR (f_addr),
        .FETCH_ACK  (f_ack),
        .FETCH_DATA (f_data),
        .DATA_REQ   (d_req),
        .DATA_WE    (d_we),
        .DATA_ADDR  (d_addr),
        .DATA_WDATA (d_wdata),
        .DATA_ACK   (d_ack),
        .DATA_RDATA (d_rdata),
        .DATA_ERR   (d_err),
        .MEM_ADDR   (m_addr_o),
        .MEM_WDATA  (m_wdata_o),
        .MEM_RDATA  (m_rdata),
        .MEM_OE_bar (oe_bar),
        .MEM_WE_bar (we_bar),
        .BUSY       (busy)
    );

    // Memory model: async read, write on clock while WE_bar is low
    logic [7:0] mem [0:65535];
    bit mem_loaded = 1'b0;
    assign m_rdata = mem[m_addr_o];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (!we_bar) begin
            mem[m_addr_o] <= m_wdata_o;
        end
    end

    // Wait-state sweep instances (fetch only)
    logic        w0_req = 1'b0, w15_req = 1'b0;
    logic [15:0] w_addr = 16'h0010;
    logic        w0_ack, w15_ack, w0_dack, w15_dack, w0_err, w15_err;
    logic [7:0]  w0_fd, w15_fd, w0_dd, w15_dd, w0_wd, w15_wd;
    logic [15:0] w0_ma, w15_ma;
    logic        w0_oe, w15_oe, w0_we, w15_we, w0_busy, w15_busy;
    logic [7:0]  w0_rd, w15_rd;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = '0;
    logic [7:0]  zero8 = '0;
    assign w0_rd  = w0_ma[7:0] ^ 8'h5A;
    assign w15_rd = w15_ma[7:0] ^ 8'h5A;

    mem_bus_arbiter #(.ROM_READ_WAIT(0)) dut_w0 (
        .CLK(clk), .RST(rst),
        .FETCH_REQ(w0_req), .FETCH_ADDR(w_addr),
        .FETCH_ACK(w0_ack), .FETCH_DATA(w0_fd),
        .DATA_REQ(zero1), .DATA_WE(zero1), .DATA_ADDR(zero16),
        .DATA_WDATA(zero8), .DATA_ACK(w0_dack), .DATA_RDATA(w0_dd),
        .DATA_ERR(w0_err), .MEM_ADDR(w0_ma), .MEM_WDATA(w0_wd),
        .MEM_RDATA(w0_rd), .MEM_OE_bar(w0_oe), .MEM_WE_bar(w0_we),
        .BUSY(w0_busy)
    );

    mem_bus_arbiter #(.ROM_READ_WAIT(15)) dut_w15 (
        .CLK(clk), .RST(rst),
        .FETCH_REQ(w15_req), .FETCH_ADDR(w_addr),
        .FETCH_ACK(w15_ack), .FETCH_DATA(w15_fd),
        .DATA_REQ(zero1), .DATA_WE(zero1), .DATA_ADDR(zero16),
        .DATA_WDATA(zero8), .DATA_ACK(w15_dack), .DATA_RDATA(w15_dd),
        .DATA_ERR(w15_err), .MEM_ADDR(w15_ma), .MEM_WDATA(w15_wd),
        .MEM_RDATA(w15_rd), .MEM_OE_bar(w15_oe), .MEM_WE_bar(w15_we),
        .BUSY(w15_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: each grant becomes a window of interval indices
    // (interval e = time after clock edge e).
    int n = 0;
    always @(posedge clk) n <= n + 1;

    logic [7:0]  ref_mem [0:65535];
    bit          ref_loaded = 1'b0;
    bit          m_act = 1'b0, m_g = 1'b0, m_last = 1'b1;
    bit          m_we = 1'b0, m_romwr = 1'b0;
    int          m_start = 1, m_end = 0, m_done = -10, m_free = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_rd = '0;
    logic [7:0]  e_fdata = '0, e_ddata = '0;

    logic        m_gd, m_gwe, m_gram;
    logic [15:0] m_ga;
    int          m_gw;
    assign m_gd   = d_req && (!f_req || !m_last);
    assign m_ga   = m_gd ? d_addr : f_addr;
    assign m_gwe  = m_gd && d_we;
    assign m_gram = (m_ga >= 16'h8000);
    assign m_gw   = m_gwe ? RAM_WW : (m_gram ? RAM_RW : ROM_RW);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (!ref_loaded) begin
                for (int i = 0; i < 65536; i++) ref_mem[i] <= init_byte(i);
                ref_loaded <= 1'b1;
            end
            m_act   <= 1'b0;
            m_last  <= 1'b1;
            m_free  <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            e_fdata <= '0;
            e_ddata <= '0;
        end else begin
            if (m_act && n == m_done && !m_we) begin
                if (m_g) e_ddata <= m_rd;
                else     e_fdata <= m_rd;
            end
            if (n >= m_free && (f_req || d_req)) begin
                m_act   <= 1'b1;
                m_g     <= m_gd;
                m_last  <= m_gd;
                m_we    <= m_gwe;
                m_romwr <= m_gwe && !m_gram;
                m_addr  <= m_ga;
                if (m_gd) m_wdata <= d_wdata;
                m_start <= n;
                m_end   <= n + m_gw;
                m_done  <= n + m_gw + 1 + (m_gwe ? 1 : 0);
                m_free  <= n + m_gw + 3 + (m_gwe ? 1 : 0);
                m_rd    <= ref_mem[m_ga];
                if (m_gwe && m_gram) ref_mem[m_ga] <= d_wdata;
            end
        end
    end

    bit started = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            int  ci;
            bit  in_acc, in_busy;
            ci      = n - 1;
            in_acc  = m_act && ci >= m_start && ci <= m_end;
            in_busy = m_act && ci >= m_start && ci <= m_done;
            chk("oe_bar", oe_bar, !(in_acc && !m_we));
            chk("we_bar", we_bar, !(in_acc && m_we && !m_romwr));
            chk("busy", busy, in_busy);
            chk("fetch_ack", f_ack, m_act && ci == m_done && !m_g);
            chk("data_ack", d_ack, m_act && ci == m_done && m_g);
            chk("data_err", d_err, m_act && ci == m_done && m_g && m_romwr);
            chk("mem_addr", m_addr_o, m_addr);
            chk("fetch_data", f_data, e_fdata);
            chk("data_rdata", d_rdata, e_ddata);
            if (in_busy && m_we) chk("mem_wdata", m_wdata_o, m_wdata);
            if (!oe_bar && !we_bar) chk("strobes_both_low", 1, 0);
        end
    end

    task automatic run_fetch(input logic [15:0] a, output int k,
                             output int oe, output logic [7:0] rd);
        @(negedge clk);
        f_req = 1'b1; f_addr = a;
        k = -1; oe = 0; rd = '0;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!oe_bar) oe++;
            if (f_ack) begin
                k = i; rd = f_data; f_req = 1'b0;
                break;
            end
            @(posedge clk);
        end
        f_req = 1'b0;
    endtask

    task automatic run_data(input logic we, input logic [15:0] a,
                            input logic [7:0] wd, output int k,
                            output int stb, output logic [7:0] rd,
                            output logic er);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        k = -1; stb = 0; rd = '0; er = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (we ? !we_bar : !oe_bar) stb++;
            if (d_ack) begin
                k = i; rd = d_rdata; er = d_err; d_req = 1'b0;
                break;
            end
            @(posedge clk);
        end
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, stb, k0, k15, who;
        logic [7:0] rd;
        logic er;
        int order[$];

        #1 rst = 1'b1;
        started = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_oe_bar", oe_bar, 1);
        chk("rst_we_bar", we_bar, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", m_addr_o, 0);
        chk("rst_fetch_data", f_data, 0);
        chk("rst_acks", {f_ack, d_ack, d_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch read from ROM
        run_fetch(16'h0010, k, stb, rd);
        chk("rom_fetch_latency", k, 2);
        chk("rom_fetch_oe_cycles", stb, 2);
        chk("rom_fetch_data", rd, 8'hA5);

        // RAM write then read-back
        run_data(1'b1, 16'h8001, 8'h3C, k, stb, rd, er);
        chk("ram_write_latency", k, 2);
        chk("ram_write_we_cycles", stb, 1);
        chk("ram_write_err", er, 0);
        run_data(1'b0, 16'h8001, 8'h00, k, stb, rd, er);
        chk("ram_read_latency", k, 1);
        chk("ram_read_data", rd, 8'h3C);
        chk("fetch_data_untouched", f_data, 8'hA5);

        // Write to top of ROM is refused
        run_data(1'b1, 16'h7FFF, 8'h11, k, stb, rd, er);
        chk("rom_write_latency", k, 2);
        chk("rom_write_we_cycles", stb, 0);
        chk("rom_write_err", er, 1);
        chk("rom_7fff_unchanged", mem[16'h7FFF], 8'h80);

        // Both requesters hammering the bus
        fork
            begin
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    f_req = 1'b1; f_addr = 16'h0010;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        if (f_ack) begin
                            order.push_back(0);
                            break;
                        end
                    end
                    f_req = 1'b0;
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFF;
                    for (int t = 0; t < 40; t++) begin
                        @(negedge clk);
                        if (d_ack) begin
                            order.push_back(1);
                            break;
                        end
                    end
                    d_req = 1'b0;
                end
            end
        join
        chk("rr_ack_count", order.size(), 4);
        for (int i = 1; i < order.size(); i++)
            chk("rr_alternate", order[i] != order[i-1], 1);

        // Reset during the second ACCESS cycle of a ROM fetch
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0010;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_oe_bar", oe_bar, 1);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        f_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ack_after_abort", {f_ack, d_ack}, 0);
        end
        chk("idle_after_release", busy, 0);

        // First tie after reset goes to fetch
        f_req = 1'b1; f_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        who = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (f_ack) begin
                who = 0; f_req = 1'b0;
                break;
            end
            if (d_ack) begin
                who = 1; d_req = 1'b0;
                break;
            end
        end
        chk("tie_after_reset_fetch", who, 0);
        for (int t = 0; t < 40 && d_req; t++) begin
            @(negedge clk);
            if (d_ack) d_req = 1'b0;
        end
        chk("tie_data_served", d_req, 0);
        @(negedge clk);

        // Wait-state sweep on ROM reads
        k0 = -1; k15 = -1;
        @(negedge clk);
        w0_req = 1'b1; w15_req = 1'b1;
        @(posedge clk);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (w0_ack) begin
                        k0 = i; w0_req = 1'b0;
                        break;
                    end
                    @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (w15_ack) begin
                        k15 = i; w15_req = 1'b0;
                        break;
                    end
                    @(posedge clk);
                end
            end
        join
        w0_req = 1'b0; w15_req = 1'b0;
        chk("w0_latency", k0, 1);
        chk("w15_latency", k15, 16);
        chk("w0_data", w0_fd, 8'h4A);
        chk("w15_data", w15_fd, 8'h4A);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
